muldiv_unit: RTL and testbench

//  Iterative RV32M-style multiply/divide unit with a valid/ready handshake on both sides.

---
 rtl/muldiv_unit.sv | 98 +++++++++
 tb/tb_muldiv_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready handshake on both sides
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;
  logic [2:0] op;
  logic sa, sb;
  logic [W-1:0] m, res;
  logic [2*W-1:0] p;
  logic [CW-1:0] cnt;
  logic [TAG_WIDTH-1:0] tag;
  logic in_sa, in_sb, div_zero, ovf, mul_zero, special, accept;
  logic [W-1:0] mag_a, mag_b, spec_res, quo, rem, fix;
  logic [W:0] mul_sum, div_sh, div_diff;
  logic [2*W-1:0] mul_next, div_next, prod;
  assign in_ready   = state == IDLE;
  assign out_valid  = state == DONE;
  assign busy       = state != IDLE;
  assign out_result = res;
  assign out_tag    = tag;
  assign accept     = in_valid & in_ready & ~flush;
  // Signedness of each operand by funct3; MULHSU treats only a as signed
  assign in_sa    = in_a[W-1] & (in_op == 3'd1 | in_op == 3'd2 | in_op == 3'd4 | in_op == 3'd6);
  assign in_sb    = in_b[W-1] & (in_op == 3'd1 | in_op == 3'd4 | in_op == 3'd6);
  assign mag_a    = in_sa ? -in_a : in_a;
  assign mag_b    = in_sb ? -in_b : in_b;
  assign div_zero = in_op[2] & ~|in_b;
  assign ovf      = in_op[2] & ~in_op[0] & (in_a == MIN_INT) & (&in_b);
  assign mul_zero = ~in_op[2] & (~|in_a | ~|in_b);
  assign special  = div_zero | ovf | mul_zero;
  assign spec_res = div_zero ? (in_op[1] ? in_a : '1) : ovf ? (in_op[1] ? '0 : MIN_INT) : '0;
  // Shift-add keeps the carry of the partial product; restoring divide keeps {rem, quotient}
  assign mul_sum  = {1'b0, p[2*W-1:W]} + {1'b0, m};
  assign mul_next = p[0] ? {mul_sum, p[W-1:1]} : {1'b0, p[2*W-1:1]};
  assign div_sh   = {p[2*W-1:W], p[W-1]};
  assign div_diff = div_sh - {1'b0, m};
  assign div_next = div_diff[W] ? {div_sh[W-1:0], p[W-2:0], 1'b0} : {div_diff[W-1:0], p[W-2:0], 1'b1};
  assign prod     = (sa ^ sb) ? -p : p;
  assign quo      = (sa ^ sb) ? -p[W-1:0] : p[W-1:0];
  assign rem      = sa ? -p[2*W-1:W] : p[2*W-1:W];
  assign fix      = op[2] ? (op[1] ? rem : quo) : (op[1:0] == 2'd0 ? prod[W-1:0] : prod[2*W-1:W]);
  always_comb begin
    state_d = state;
    if (flush) state_d = IDLE;
    else if (state == IDLE) state_d = accept ? (special ? DONE : BUSY) : IDLE;
    else if (state == BUSY) state_d = (cnt == CW'(W)) ? DONE : BUSY;
    else state_d = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      m     <= '0;
      p     <= '0;
      cnt   <= '0;
      res   <= '0;
      tag   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op  <= in_op;
        sa  <= in_sa;
        sb  <= in_sb;
        m   <= mag_b;
        p   <= {{W{1'b0}}, mag_a};
        cnt <= '0;
        tag <= in_tag;
        if (special) res <= spec_res;
      end else if (state == BUSY && !flush) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(W)) res <= fix;
        else p <= op[2] ? div_next : mul_next;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results and latencies
module tb_muldiv_unit;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [2:0] in_op = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic [4:0] in_tag = 0;
  logic in_ready, out_valid, busy;
  logic [31:0] out_result;
  logic [4:0] out_tag;
  int tests = 0, fails = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    @(negedge clk);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = t;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({name, " latency"}, n, lat);
  endtask

  task automatic handshake(input string name);
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check({name, " in_ready after handshake"}, {31'd0, in_ready}, 1);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] t, input logic [31:0] exp, input int lat);
    issue(op, a, b, t);
    wait_done(name, lat);
    check({name, " result"}, out_result, exp);
    check({name, " tag"}, {27'd0, out_tag}, {27'd0, t});
    handshake(name);
  endtask

  initial begin
    int seen;
    #2;
    check("reset in_ready", {31'd0, in_ready}, 1);
    check("reset out_valid", {31'd0, out_valid}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset result", out_result, 0);
    @(negedge clk) rst = 0;

    run("MUL 7*-3",         3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34);
    run("MULH min*min",     3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 34);
    run("MULHU 2^31*2^31",  3'd3, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 34);
    run("MULHSU -1*ffff",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34);
    run("MULHU big",        3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 34);
    run("DIV -7/2",         3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 34);
    run("REM -7/2",         3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 34);
    run("DIVU 100/7",       3'd5, 32'd100,      32'd7,        5'd8,  32'd14,       34);
    run("REMU 100/7",       3'd7, 32'd100,      32'd7,        5'd9,  32'd2,        34);
    run("DIVU max/1",       3'd5, 32'hFFFFFFFF, 32'd1,        5'd10, 32'hFFFFFFFF, 34);
    run("DIV 5/0",          3'd4, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
    run("REM 5/0",          3'd6, 32'd5,        32'd0,        5'd12, 32'd5,        1);
    run("DIV ovf",          3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1);
    run("REM ovf",          3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1);
    run("MUL by zero",      3'd0, 32'd0,        32'd1234,     5'd15, 32'd0,        1);

    issue(3'd5, 32'd100, 32'd7, 5'd21);
    wait_done("bp", 34);
    repeat (10) @(posedge clk);
    #1;
    check("bp out_valid held", {31'd0, out_valid}, 1);
    check("bp result held", out_result, 32'd14);
    check("bp tag held", {27'd0, out_tag}, 32'd21);
    check("bp in_ready low", {31'd0, in_ready}, 0);
    handshake("bp");
    check("bp out_valid dropped", {31'd0, out_valid}, 0);

    issue(3'd4, 32'd1000, 32'd3, 5'd22);
    repeat (9) @(posedge clk);
    @(negedge clk) begin flush = 1; in_valid = 1; in_op = 3'd4; in_a = 32'd5; in_b = 32'd0; end
    @(posedge clk);
    #1 flush = 0; in_valid = 0;
    check("flush busy", {31'd0, busy}, 0);
    check("flush in_ready", {31'd0, in_ready}, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 seen += out_valid;
    end
    check("flush no out_valid", seen, 0);

    issue(3'd0, 32'd12345, 32'd678, 5'd23);
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst busy", {31'd0, busy}, 0);
    check("rst in_ready", {31'd0, in_ready}, 1);
    check("rst result", out_result, 0);
    check("rst tag", {27'd0, out_tag}, 0);
    @(negedge clk) rst = 0;
    run("MUL after rst", 3'd0, 32'd12345, 32'd678, 5'd24, 32'd8369910, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
